// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch I / load-store D) sharing one 32-bit memory port.
// Latency: grant registered one cycle after req in IDLE; ack one cycle after mem_ready; DONE -> IDLE.
// Backpressure: requests stay pending while BUSY/DONE; mem_ready stalls BUSY up to TIMEOUT cycles.
//
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   i_req/i_addr -> i_ack/i_rdata     - instruction fetch side
//   d_req/d_we/d_addr/d_wdata/d_be
//                -> d_ack/d_rdata     - load/store side
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be, mem_ready/mem_rdata - memory port
//   sel                               - current owner (0 = I, 1 = D), drives 2:1 selector Control
//   timeout_err                       - sticky watchdog flag
module mem_port_arbiter #(
  parameter int BURST_LIMIT = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        sel,
  output logic        timeout_err
);

  localparam logic [3:0]  BLIM  = 4'(BURST_LIMIT);
  localparam logic [15:0] WLAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  burst_cnt, burst_cnt_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;

  logic        i_ack_nxt, d_ack_nxt;
  logic [31:0] i_rdata_nxt, d_rdata_nxt;
  logic        mem_req_nxt, mem_we_nxt;
  logic [31:0] mem_addr_nxt, mem_wdata_nxt;
  logic [3:0]  mem_be_nxt;
  logic        sel_nxt, timeout_err_nxt;

  logic grant_d, grant_i, done_ok, done_to;

  // D wins unless fetch is waiting and D has already used its burst allowance.
  assign grant_d = (state == IDLE) && d_req && (!i_req || (burst_cnt < BLIM));
  assign grant_i = (state == IDLE) && !grant_d && i_req;
  // A ready on the final wait cycle is a normal completion, not a timeout.
  assign done_ok = (state == BUSY) && mem_ready;
  assign done_to = (state == BUSY) && !mem_ready && (wait_cnt == WLAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_d || grant_i) state_nxt = BUSY;
      BUSY:    if (done_ok || done_to) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and counters
  always_comb begin
    i_ack_nxt       = 1'b0;
    d_ack_nxt       = 1'b0;
    i_rdata_nxt     = i_rdata;
    d_rdata_nxt     = d_rdata;
    mem_req_nxt     = mem_req;
    mem_we_nxt      = mem_we;
    mem_addr_nxt    = mem_addr;
    mem_wdata_nxt   = mem_wdata;
    mem_be_nxt      = mem_be;
    sel_nxt         = sel;
    timeout_err_nxt = timeout_err;
    burst_cnt_nxt   = burst_cnt;
    wait_cnt_nxt    = wait_cnt;

    case (state)
      IDLE: begin
        if (grant_d) begin
          sel_nxt       = 1'b1;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = d_we;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
          mem_be_nxt    = d_be;
          wait_cnt_nxt  = 16'd0;
          // Consecutive D grants are only counted while fetch is waiting.
          if (!i_req)              burst_cnt_nxt = 4'd0;
          else if (burst_cnt != 4'hF) burst_cnt_nxt = burst_cnt + 4'd1;
        end else if (grant_i) begin
          sel_nxt       = 1'b0;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b0;
          mem_addr_nxt  = i_addr;
          mem_wdata_nxt = 32'h0;
          mem_be_nxt    = 4'b1111;
          wait_cnt_nxt  = 16'd0;
          burst_cnt_nxt = 4'd0;
        end
      end
      BUSY: begin
        wait_cnt_nxt = wait_cnt + 16'd1;
        if (done_ok || done_to) begin
          mem_req_nxt = 1'b0;
          if (done_to) timeout_err_nxt = 1'b1;
          if (sel) begin
            d_ack_nxt = 1'b1;
            // Stores never touch d_rdata; an aborted load returns zero.
            if (!mem_we) d_rdata_nxt = done_ok ? mem_rdata : 32'h0;
          end else begin
            i_ack_nxt   = 1'b1;
            i_rdata_nxt = done_ok ? mem_rdata : 32'h0;
          end
        end
      end
      default: ;
    endcase
  end

  // Output / counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      i_rdata     <= 32'h0;
      d_rdata     <= 32'h0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      mem_be      <= 4'h0;
      sel         <= 1'b0;
      timeout_err <= 1'b0;
      burst_cnt   <= 4'd0;
      wait_cnt    <= 16'd0;
    end else begin
      i_ack       <= i_ack_nxt;
      d_ack       <= d_ack_nxt;
      i_rdata     <= i_rdata_nxt;
      d_rdata     <= d_rdata_nxt;
      mem_req     <= mem_req_nxt;
      mem_we      <= mem_we_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_wdata   <= mem_wdata_nxt;
      mem_be      <= mem_be_nxt;
      sel         <= sel_nxt;
      timeout_err <= timeout_err_nxt;
      burst_cnt   <= burst_cnt_nxt;
      wait_cnt    <= wait_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: grants and acks are predicted at stimulus time,
// monitors compare them whenever the DUT raises mem_req or an ack.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        sel, timeout_err;

  mem_port_arbiter #(.BURST_LIMIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .sel(sel), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          len;
  } gexp_t;

  typedef struct {
    logic        is_d;
    logic [31:0] ir;
    logic [31:0] dr;
    logic        terr;
  } aexp_t;

  gexp_t grant_q[$];
  aexp_t ack_q[$];

  int checks = 0;
  int fails  = 0;

  logic [31:0] model_i = 32'h0;
  logic [31:0] model_d = 32'h0;

  // memory model configuration
  int          mem_wait  = 0;
  logic        mem_never = 1'b0;
  logic        use_addr  = 1'b0;
  logic [31:0] rdata_val = 32'h0;
  int          busy_k    = 0;

  function automatic void chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Memory: mem_ready asserted in BUSY cycle mem_wait+1, unless mem_never.
  always @(negedge clk) begin
    if (mem_req) busy_k = busy_k + 1;
    else         busy_k = 0;
    mem_ready = mem_req && !mem_never && (busy_k == mem_wait + 1);
    mem_rdata = use_addr ? ~mem_addr : rdata_val;
  end

  // Grant monitor: payload on rising mem_req, stability while high, length on fall.
  logic        g_prev = 1'b0;
  int          g_len  = 0;
  gexp_t       g_cur;
  always @(negedge clk) begin
    if (mem_req && !g_prev) begin
      if (grant_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_grant: got sel=%0b addr=%0h expected none", sel, mem_addr);
        g_cur.len = -1;
      end else begin
        g_cur = grant_q.pop_front();
        chk("grant_sel",   96'(sel),       96'(g_cur.sel));
        chk("grant_addr",  96'(mem_addr),  96'(g_cur.addr));
        chk("grant_we",    96'(mem_we),    96'(g_cur.we));
        chk("grant_wdata", 96'(mem_wdata), 96'(g_cur.wdata));
        chk("grant_be",    96'(mem_be),    96'(g_cur.be));
      end
      g_len = 1;
    end else if (mem_req && g_prev) begin
      g_len++;
      chk("payload_stable", {sel, mem_addr, mem_we, mem_wdata, mem_be},
          {g_cur.sel, g_cur.addr, g_cur.we, g_cur.wdata, g_cur.be});
    end else if (!mem_req && g_prev && g_cur.len >= 0) begin
      chk("mem_req_len", 96'(g_len), 96'(g_cur.len));
    end
    g_prev = mem_req;
  end

  // Ack monitor
  always @(negedge clk) begin
    if (i_ack || d_ack) begin
      chk("ack_exclusive", 96'(i_ack & d_ack), 96'(0));
      if (ack_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_ack: got i_ack=%0b d_ack=%0b expected none", i_ack, d_ack);
      end else begin
        aexp_t e;
        e = ack_q.pop_front();
        chk("ack_owner",   96'(d_ack),       96'(e.is_d));
        chk("i_rdata",     96'(i_rdata),     96'(e.ir));
        chk("d_rdata",     96'(d_rdata),     96'(e.dr));
        chk("timeout_err", 96'(timeout_err), 96'(e.terr));
      end
    end
  end

  function automatic void predict(input logic is_d, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be,
                                  input logic never, input logic [31:0] rd,
                                  input logic terr, input int len);
    gexp_t g;
    aexp_t a;
    g.sel   = is_d;
    g.addr  = addr;
    g.we    = is_d ? we : 1'b0;
    g.wdata = is_d ? wdata : 32'h0;
    g.be    = is_d ? be : 4'b1111;
    g.len   = len;
    grant_q.push_back(g);
    if (is_d) begin
      if (!we) model_d = never ? 32'h0 : rd;
    end else begin
      model_i = never ? 32'h0 : rd;
    end
    a.is_d = is_d;
    a.ir   = model_i;
    a.dr   = model_d;
    a.terr = terr;
    ack_q.push_back(a);
  endfunction

  task automatic do_req(input logic is_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int waitc,
                        input logic never, input logic [31:0] rd, input logic terr, input int len);
    logic got;
    predict(is_d, we, addr, wdata, be, never, rd, terr, len);
    mem_wait  = waitc;
    mem_never = never;
    use_addr  = 1'b0;
    rdata_val = rd;
    @(posedge clk); #1;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (is_d ? d_ack : i_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (is_d) d_req = 1'b0;
    else      i_req = 1'b0;
    if (!got) begin
      checks++; fails++;
      $display("FAIL ack_wait: got no ack within 40 cycles expected one");
    end
  endtask

  task automatic rst_pulse();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_i = 32'h0;
    model_d = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int acks;
    rst = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // reset state
    chk("rst_ctrl", 96'({i_ack, d_ack, mem_req, mem_we, sel, timeout_err}), 96'(0));
    chk("rst_rdata", {32'h0, i_rdata, d_rdata}, 96'(0));
    chk("rst_mem",   {28'h0, mem_be, mem_addr, mem_wdata}, 96'(0));
    #1 rst = 1'b0;

    // reset mid-transfer: grant D, never ready, reset in BUSY
    mem_never = 1'b1;
    begin
      gexp_t g;
      g.sel = 1'b1; g.addr = 32'h1001_0040; g.we = 1'b0;
      g.wdata = 32'h0000_00AA; g.be = 4'b0001; g.len = 2;
      grant_q.push_back(g);
    end
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0040; d_wdata = 32'h0000_00AA; d_be = 4'b0001;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_mem_req", 96'(mem_req), 96'(0));
    chk("midrst_sel", 96'(sel), 96'(0));
    chk("midrst_terr", 96'(timeout_err), 96'(0));
    repeat (12) @(negedge clk);
    mem_never = 1'b0;

    // fetch read, zero wait
    do_req(1'b0, 1'b0, 32'h0040_0000, 32'h0, 4'h0, 0, 1'b0, 32'h8C08_0004, 1'b0, 1);
    @(negedge clk);
    chk("i_ack_one_cycle", 96'(i_ack), 96'(0));

    // contention: both held, zero-wait memory
    use_addr = 1'b1; mem_wait = 0; mem_never = 1'b0;
    i_addr = 32'h0000_1000;
    d_we = 1'b0; d_addr = 32'h2000_0040; d_wdata = 32'h5555_AAAA; d_be = 4'b0011;
    for (int n = 0; n < 10; n++) begin
      if ((n % 5) != 4) predict(1'b1, 1'b0, 32'h2000_0040, 32'h5555_AAAA, 4'b0011, 1'b0, ~32'h2000_0040, 1'b0, 1);
      else              predict(1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 1'b0, ~32'h0000_1000, 1'b0, 1);
    end
    @(posedge clk); #1;
    i_req = 1'b1; d_req = 1'b1;
    acks = 0;
    for (int c = 0; c < 200 && acks < 10; c++) begin
      @(negedge clk);
      if (i_ack || d_ack) acks++;
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("contention_acks", 96'(acks), 96'(10));
    use_addr = 1'b0;

    // store with 2 wait cycles: d_rdata keeps the last load value
    do_req(1'b1, 1'b1, 32'h1001_0000, 32'h1234_5678, 4'b1111, 2, 1'b0, 32'hFFFF_0000, 1'b0, 3);

    // timeout on a load, then error stays set across a later fetch
    do_req(1'b1, 1'b0, 32'h1001_0100, 32'h0, 4'b1111, 0, 1'b1, 32'h0, 1'b1, 8);
    do_req(1'b0, 1'b0, 32'h0040_0004, 32'h0, 4'h0, 1, 1'b0, 32'h2402_0001, 1'b1, 2);
    @(negedge clk);
    chk("terr_sticky", 96'(timeout_err), 96'(1));
    rst_pulse();
    @(negedge clk);
    chk("terr_cleared", 96'(timeout_err), 96'(0));

    // ready on the final wait cycle wins over the timeout
    do_req(1'b1, 1'b0, 32'h1001_0200, 32'h0, 4'b1111, 7, 1'b0, 32'hCAFE_F00D, 1'b0, 8);

    repeat (5) @(negedge clk);
    chk("ack_q_empty",   96'(ack_q.size()),   96'(0));
    chk("grant_q_empty", 96'(grant_q.size()), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single 32-bit memory port between two requesters: instruction fetch (I) and the load/store unit (D). It uses a three-state controller, a starvation guard that bounds consecutive data grants while fetch waits, and a ready-timeout watchdog. Its registered `sel` output drives the `Control` input of the 32-bit 2:1 selectors that steer memory-side signals:
- 0 selects the instruction side.
- 1 selects the data side.

## Interface
Parameters:
- `BURST_LIMIT`, default 4: maximum consecutive D grants issued while `i_req` is pending; range 1–15.
- `TIMEOUT`, default 255: maximum cycles `mem_req` stays high without `mem_ready`; range 1–65535; uses a 16-bit wait counter.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `i_req` in 1: fetch request; held until `i_ack`.
- `i_addr` in 32: fetch address.
- `i_ack` out 1: one-cycle completion pulse to fetch.
- `i_rdata` out 32: registered fetch data.
- `d_req` in 1: data request; held until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_be` in 4: byte enables.
- `d_ack` out 1: one-cycle completion pulse to data.
- `d_rdata` out 32: registered load data.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_be` out 4: memory byte enables.
- `mem_ready` in 1: memory completion; sampled only in BUSY.
- `mem_rdata` in 32: memory read data; valid when `mem_ready` = 1.
- `sel` out 1: current owner (0 = I, 1 = D); drives the 2:1 selector `Control`.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
States: IDLE, BUSY, DONE.

IDLE, grant decision:
- Grant D if `d_req` && (!`i_req` || `burst_cnt` < `BURST_LIMIT`).
- Otherwise grant I if `i_req`.
- Otherwise stay in IDLE.

On a grant, move to BUSY and register:
- `sel` = owner.
- `mem_req` = 1.
- `mem_addr` from the owner's address.
- For D: `mem_we` = `d_we`, `mem_wdata` = `d_wdata`, `mem_be` = `d_be`.
- For I: `mem_we` = 0, `mem_be` = 4'b1111, `mem_wdata` = 0.
- `wait_cnt` = 0.

`burst_cnt` (4-bit) update at grant time:
- D grant with `i_req` = 1: increment, saturating.
- D grant with `i_req` = 0: clear to 0.
- I grant: clear to 0.

BUSY:
- All `mem_*` outputs and `sel` are held stable.
- `wait_cnt` increments each cycle.
- If `mem_ready` = 1: `mem_req` = 0, the owner's ack = 1, go to DONE. For a load or fetch, the owner's rdata register captures `mem_rdata`. A store leaves `d_rdata` unchanged.
- Else if `wait_cnt` == `TIMEOUT`−1: abort.
  - `mem_req` = 0, owner's ack = 1, owner's rdata = 32'h0.
  - For a store, `d_rdata` is unchanged.
  - `timeout_err` = 1; it is sticky until `rst`.
  - Go to DONE.
- If `mem_ready` arrives on the final wait cycle, normal completion wins: no error, data is captured.

DONE:
- Ack is high for this cycle only.
- Next cycle: ack = 0, go to IDLE. No grant is made from DONE.

Requester rules:
- Requests arriving in BUSY or DONE stay pending.
- A requester holds `req` and its payload stable until it samples its ack.
- On the ack cycle, the requester drops `req` or presents the next request.
- The arbiter samples payload only at grant.

`i_ack` and `d_ack` are never high in the same cycle.

## Timing
- Reset values: state = IDLE; every output = 0 (including `sel`, `i_rdata`, `d_rdata`, `timeout_err`); `burst_cnt` = 0; `wait_cnt` = 0.
- `rst` in any state, including mid-BUSY: the transfer is abandoned. Next cycle `mem_req` = 0 and no ack is issued.
- Minimum latency, with `req` high in cycle 0 and IDLE:
  - cycle 1: `mem_req` = 1.
  - cycle 1: `mem_ready` = 1.
  - cycle 2: ack = 1, rdata valid.
  - cycle 3: IDLE.
- Peak throughput: one transfer per 3 cycles.
- Each wait cycle with `mem_ready` = 0 adds one cycle.
- On timeout, `mem_req` is high for exactly `TIMEOUT` cycles.
- rdata outputs hold their value until the next completion for that requester.

## Test plan
- **Reset mid-transfer.** Stimulus: `d_req` granted, `mem_ready` held 0, `rst` pulsed for 1 cycle in BUSY. Required: next cycle `mem_req` = 0, `sel` = 0, `timeout_err` = 0; no `d_ack` ever issued.
- **Fetch read.** Stimulus: `i_req`, `i_addr` = 32'h0040_0000; `mem_ready` = 1 in the first BUSY cycle with `mem_rdata` = 32'h8C08_0004. Required: `mem_addr` = 32'h0040_0000, `sel` = 0, `mem_we` = 0; `i_ack` high exactly 1 cycle; `i_rdata` = 32'h8C08_0004.
- **Store with 2 wait cycles.** Stimulus: `d_we` = 1, `d_addr` = 32'h1001_0000, `d_wdata` = 32'h1234_5678, `d_be` = 4'b1111. Required: `sel` = 1; `mem_req` high 3 cycles with stable payload; one `d_ack`; `d_rdata` unchanged.
- **Contention.** Stimulus: `i_req` and `d_req` held high, `BURST_LIMIT` = 4, zero-wait memory. Required: grant sequence D, D, D, D, I, D, D, D, D, I; no simultaneous acks.
- **Timeout.** Stimulus: `TIMEOUT` = 8, D load, `mem_ready` never asserted. Required: `mem_req` high exactly 8 cycles, then `d_ack` = 1 with `d_rdata` = 0; `timeout_err` = 1 and stays 1 through later transfers until `rst`.
- **Ready on the last wait cycle.** Stimulus: `TIMEOUT` = 8, `mem_ready` = 1 in the 8th BUSY cycle with `mem_rdata` = 32'hCAFE_F00D. Required: normal completion with `d_rdata` = 32'hCAFE_F00D and `timeout_err` = 0.
